mod_soft_step_grad: RTL and testbench

Backward-pass companion to the soft-step activation. During the forward pass it records, per neuron sample, whether the FP16 pre-activation fell in the linear region (|x| < 1.0) or the saturated region (|x| ≥ 1.0). During the backward pass it replays those flags in FIFO order and gates each incoming FP16 gradient: linear region passes the gradient, saturated region outputs signed zero. It sits between the forward activation stage and the gradient path of the training datapath.

---
 rtl/mod_soft_step_grad_if.sv | 46 ++++
 rtl/mod_soft_step_grad.sv | 106 ++++++++++
 tb/tb_mod_soft_step_grad.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_soft_step_grad_if.sv
// Handshake bundle for mod_soft_step_grad: forward mask push, gradient pop, gated output.
// Latency: none (wires only). Backpressure: fwdReady/gradReady/outReady carried as plain signals.
// ADDR_W sizes the occupancy count (ADDR_W+1 bits, 0..DEPTH).
interface mod_soft_step_grad_if #(
    parameter int ADDR_W = 4
);
    logic              flush;
    logic              fwdValid;
    logic [15:0]       fwdVal;
    logic              fwdReady;
    logic              gradValid;
    logic [15:0]       gradVal;
    logic              gradReady;
    logic              outValid;
    logic [15:0]       outVal;
    logic              outReady;
    logic [ADDR_W:0]   count;

    modport slave (
        input  flush,
        input  fwdValid,
        input  fwdVal,
        output fwdReady,
        input  gradValid,
        input  gradVal,
        output gradReady,
        output outValid,
        output outVal,
        input  outReady,
        output count
    );

    modport master (
        output flush,
        output fwdValid,
        output fwdVal,
        input  fwdReady,
        output gradValid,
        output gradVal,
        input  gradReady,
        input  outValid,
        input  outVal,
        output outReady,
        input  count
    );
endinterface

// File: rtl/mod_soft_step_grad.sv
// Soft-step backward gate: FIFO of linear/saturated flags from the forward pass gates FP16 gradients.
// Latency 1 cycle gradient accept -> outValid; gradReady drops when FIFO empty or output held.
// Optional SOFTSTEP_GRAD_LEAK_EN: saturated gradients scaled by 2^-4 instead of zeroed.
module mod_soft_step_grad #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mod_soft_step_grad_if.slave   io_bus
);

    localparam logic [ADDR_W:0]   LP_FULL    = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   LP_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LP_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0]   r_mask;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_out_vld;
    logic [15:0]        r_out_dat;

    logic               w_fwd_rdy;
    logic               w_grad_rdy;
    logic               w_push;
    logic               w_pop;
    logic               w_fwd_linear;
    logic               w_rd_linear;
    logic [15:0]        w_gated;

    // Exponent below the bias means |x| < 1.0; inf/NaN (exp 31) falls out as saturated.
    function automatic logic [15:0] f_gate(input logic linear, input logic [15:0] g);
        logic [4:0] e;
        e      = g[14:10];
        f_gate = {g[15], 15'h0000};
        if (linear) begin
            f_gate = g;
        end
`ifdef SOFTSTEP_GRAD_LEAK_EN
        else if (e == 5'd31) begin
            f_gate = g;
        end else if (e > 5'd4) begin
            f_gate = {g[15], e - 5'd4, g[9:0]};
        end
`endif
    endfunction

    assign w_fwd_rdy    = (r_count != LP_FULL);
    assign w_grad_rdy   = (r_count != '0) && (!r_out_vld || io_bus.outReady);
    assign w_push       = io_bus.fwdValid  && w_fwd_rdy  && !io_bus.flush;
    assign w_pop        = io_bus.gradValid && w_grad_rdy && !io_bus.flush;
    assign w_fwd_linear = (io_bus.fwdVal[14:10] < 5'b01111);
    assign w_rd_linear  = r_mask[r_rd_ptr];
    assign w_gated      = f_gate(w_rd_linear, io_bus.gradVal);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (io_bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Flag storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mask[r_wr_ptr] <= w_fwd_linear;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_dat <= 16'h0000;
        end else if (w_pop) begin
            r_out_vld <= 1'b1;
            r_out_dat <= w_gated;
        end else if (r_out_vld && io_bus.outReady) begin
            r_out_vld <= 1'b0;
        end
    end

    assign io_bus.fwdReady  = w_fwd_rdy;
    assign io_bus.gradReady = w_grad_rdy;
    assign io_bus.outValid  = r_out_vld;
    assign io_bus.outVal    = r_out_dat;
    assign io_bus.count     = r_count;

endmodule

// File: tb/tb_mod_soft_step_grad.sv
// Self-checking bench for mod_soft_step_grad: directed plan steps plus random traffic vs a queue model.
// The model keeps raw forward samples and decides linear/saturated by FP16 magnitude comparison.
module tb_mod_soft_step_grad;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

`ifdef SOFTSTEP_GRAD_LEAK_EN
    localparam logic [15:0] SAT_3C00 = 16'h2C00;
    localparam logic [15:0] SAT_C500 = 16'hB500;
`else
    localparam logic [15:0] SAT_3C00 = 16'h0000;
    localparam logic [15:0] SAT_C500 = 16'h8000;
`endif

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    logic [15:0] q[$];
    logic        m_ov;
    logic [15:0] m_oval;

    mod_soft_step_grad_if #(.ADDR_W(ADDR_W)) bus ();

    mod_soft_step_grad #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference gate: magnitude compare against 1.0 (0x3C00); leak = subtract 4 from the exponent.
    function automatic logic [15:0] ref_gate(input logic [15:0] x, input logic [15:0] g);
        logic [15:0] ax;
        logic [15:0] ag;
        ax = x & 16'h7FFF;
        ag = g & 16'h7FFF;
        if (ax < 16'h3C00) return g;
`ifdef SOFTSTEP_GRAD_LEAK_EN
        if (ag >= 16'h7C00) return g;
        if (ag < 16'h1400) return {g[15], 15'h0000};
        return g - 16'h1000;
`else
        if (ag == 16'hFFFF) return g;
        return {g[15], 15'h0000};
`endif
    endfunction

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic cyc();
        logic        fr, gr, push, pop, fl, rs, ordy;
        logic [15:0] fv, gv, x;
        #2;
        fr = (q.size() != DEPTH);
        gr = (q.size() != 0) && (!m_ov || bus.outReady);
        chk("fwdReady",  32'(bus.fwdReady),  32'(fr));
        chk("gradReady", 32'(bus.gradReady), 32'(gr));
        chk("outValid",  32'(bus.outValid),  32'(m_ov));
        chk("outVal",    32'(bus.outVal),    32'(m_oval));
        chk("count",     32'(bus.count),     32'(q.size()));
        fl   = bus.flush;
        rs   = rst_n;
        ordy = bus.outReady;
        fv   = bus.fwdVal;
        gv   = bus.gradVal;
        push = bus.fwdValid  && fr && !fl;
        pop  = bus.gradValid && gr && !fl;
        @(posedge clk);
        #1;
        if (!rs) begin
            q.delete();
            m_ov   = 1'b0;
            m_oval = 16'h0000;
        end else if (fl) begin
            q.delete();
            if (m_ov && ordy) m_ov = 1'b0;
        end else begin
            if (pop) begin
                x      = q.pop_front();
                m_oval = ref_gate(x, gv);
                m_ov   = 1'b1;
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            if (push) q.push_back(fv);
        end
    endtask

    task automatic idle();
        bus.fwdValid  = 1'b0;
        bus.gradValid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_ov     = 1'b0;
        m_oval   = 16'h0000;
        rst_n    = 1'b0;
        bus.flush     = 1'b0;
        bus.fwdValid  = 1'b0;
        bus.fwdVal    = 16'h0000;
        bus.gradValid = 1'b0;
        bus.gradVal   = 16'h0000;
        bus.outReady  = 1'b1;

        cyc();
        cyc();
        chk("rst_fwdReady",  32'(bus.fwdReady),  32'd1);
        chk("rst_gradReady", 32'(bus.gradReady), 32'd0);
        chk("rst_outValid",  32'(bus.outValid),  32'd0);
        chk("rst_outVal",    32'(bus.outVal),    32'h0000);
        chk("rst_count",     32'(bus.count),     32'd0);
        rst_n = 1'b1;

        // Linear sample passes the gradient unchanged.
        bus.fwdValid = 1'b1; bus.fwdVal = 16'h3800;
        cyc();
        idle(); bus.gradValid = 1'b1; bus.gradVal = 16'h4500;
        cyc();
        chk("lin_outValid", 32'(bus.outValid), 32'd1);
        chk("lin_outVal",   32'(bus.outVal),   32'h4500);
        idle();
        cyc();

        // Saturated sample (-1.0) zeroes the gradient, keeping sign.
        bus.fwdValid = 1'b1; bus.fwdVal = 16'hBC00;
        cyc();
        idle(); bus.gradValid = 1'b1; bus.gradVal = 16'hC500;
        cyc();
        chk("sat_outVal", 32'(bus.outVal), 32'(SAT_C500));
        idle();
        cyc();

        // Fill to DEPTH with alternating exponent 14/15, one extra push refused; drain twice for wrap.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < DEPTH + 1; i++) begin
                bus.fwdValid = 1'b1;
                bus.fwdVal   = (i % 2 == 0) ? 16'h3A00 : 16'h3E00;
                cyc();
            end
            chk("full_count",    32'(bus.count),    32'd16);
            chk("full_fwdReady", 32'(bus.fwdReady), 32'd0);
            idle();
            for (int i = 0; i < DEPTH; i++) begin
                bus.gradValid = 1'b1; bus.gradVal = 16'h3C00;
                cyc();
                chk("drain_outVal", 32'(bus.outVal), (i % 2 == 0) ? 32'h3C00 : 32'(SAT_3C00));
            end
            idle();
            cyc();
            chk("drain_count", 32'(bus.count), 32'd0);
        end

        // Output backpressure: held value, no accept; release gives back-to-back results.
        for (int i = 0; i < 3; i++) begin
            bus.fwdValid = 1'b1; bus.fwdVal = 16'h3400;
            cyc();
        end
        idle();
        bus.gradValid = 1'b1; bus.gradVal = 16'h4000;
        cyc();
        bus.outReady = 1'b0; bus.gradVal = 16'h4200;
        for (int i = 0; i < 4; i++) cyc();
        chk("bp_gradReady", 32'(bus.gradReady), 32'd0);
        chk("bp_outVal",    32'(bus.outVal),    32'h4000);
        bus.outReady = 1'b1;
        cyc();
        chk("bp_next_outVal", 32'(bus.outVal), 32'h4200);
        bus.gradVal = 16'h4400;
        cyc();
        chk("bp_b2b_outVal", 32'(bus.outVal), 32'h4400);
        idle();
        cyc();

        // Occupancy 4, then ten cycles of simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            bus.fwdValid = 1'b1; bus.fwdVal = 16'($urandom);
            cyc();
        end
        for (int i = 0; i < 10; i++) begin
            bus.fwdValid  = 1'b1; bus.fwdVal  = 16'($urandom);
            bus.gradValid = 1'b1; bus.gradVal = 16'($urandom);
            cyc();
        end
        chk("steady_count", 32'(bus.count), 32'd4);
        idle();
        for (int i = 0; i < 6; i++) begin
            bus.gradValid = 1'b1; bus.gradVal = 16'($urandom);
            cyc();
        end

        // Empty FIFO: same-cycle push does not bypass to the pop side.
        bus.fwdValid = 1'b1; bus.fwdVal = 16'h3000;
        bus.gradValid = 1'b1; bus.gradVal = 16'h5000;
        #2;
        chk("empty_gradReady", 32'(bus.gradReady), 32'd0);
        #1;
        cyc();
        bus.fwdValid = 1'b0;
        cyc();
        chk("empty_late_outVal", 32'(bus.outVal), 32'h5000);
        idle();
        cyc();

        // Flush at count 7 with a pending output that must still be delivered.
        bus.gradValid = 1'b1; bus.gradVal = 16'h4600;
        bus.fwdValid = 1'b1; bus.fwdVal = 16'h2C00;
        cyc();
        cyc();
        bus.gradValid = 1'b0; bus.outReady = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        chk("pre_flush_count", 32'(bus.count), 32'd7);
        idle();
        bus.flush = 1'b1; bus.fwdValid = 1'b1; bus.gradValid = 1'b1;
        cyc();
        idle();
        chk("flush_count",     32'(bus.count),     32'd0);
        chk("flush_gradReady", 32'(bus.gradReady), 32'd0);
        chk("flush_outValid",  32'(bus.outValid),  32'd1);
        cyc();
        bus.outReady = 1'b1;
        cyc();
        chk("flush_delivered", 32'(bus.outValid), 32'd0);

        // Random traffic with occasional flush and mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            bus.fwdValid  = ($urandom_range(0, 3) != 0);
            bus.fwdVal    = 16'($urandom);
            bus.gradValid = ($urandom_range(0, 2) != 0);
            bus.gradVal   = 16'($urandom);
            bus.outReady  = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 40) == 0);
            rst_n         = ($urandom_range(0, 80) != 0);
            cyc();
        end
        idle();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("end_rst_count",    32'(bus.count),    32'd0);
        chk("end_rst_outValid", 32'(bus.outValid), 32'd0);
        chk("end_rst_outVal",   32'(bus.outVal),   32'h0000);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
